axi_window_read_slave: RTL and testbench
========================================

AXI_WINDOW_READ_SLAVE -- requirements
Module: axi_window_read_slave

Interface
REQ-001 SHALL have parameter DATA_BYTE_WIDTH, default 32: bytes per data word.
REQ-002 SHALL have parameter DATA_BYTE_SHIFT, default 5: log2(DATA_BYTE_WIDTH); word index = araddr >> DATA_BYTE_SHIFT.
REQ-003 SHALL have parameter WINDOW_DEPTH_INDEX, default 7: word-index width.
REQ-004 SHALL have parameter WINDOW_DEPTH, default 100: number of implemented words (index 0..WINDOW_DEPTH-1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1 bit: write-port strobe.
REQ-008 SHALL have port wr_addr, input, WINDOW_DEPTH_INDEX bits: write word index.
REQ-009 SHALL have port wr_data, input, DATA_BYTE_WIDTH*8 bits: write data.
REQ-010 SHALL have AXI4 read-address inputs s_axi_arid[3:0], s_axi_araddr[31:0], s_axi_arlen[7:0], s_axi_arsize[2:0], s_axi_arburst[1:0] and s_axi_arvalid, plus output s_axi_arready.
REQ-011 SHALL have AXI4 read-data outputs s_axi_rid[3:0], s_axi_rdata[DATA_BYTE_WIDTH*8-1:0], s_axi_rresp[1:0], s_axi_rlast and s_axi_rvalid, plus input s_axi_rready.
REQ-012 SHALL have output busy, 1 bit: high whenever the block is not in the IDLE state.

Function
REQ-013 SHALL implement the three states IDLE, FETCH and SEND.
REQ-014 SHALL drive s_axi_arready=1 only in IDLE. AR handshake = arvalid & arready.
REQ-015 SHALL, on an AR handshake, latch arid, index = araddr[DATA_BYTE_SHIFT+WINDOW_DEPTH_INDEX-1:DATA_BYTE_SHIFT], beats = arlen+1 (1..256) and arburst, and then go to FETCH.
REQ-016 SHALL, in FETCH, issue a synchronous RAM read of the latched index, then go to SEND on the next cycle with rvalid=1.
REQ-017 SHALL hold rdata, rresp, rid and rlast stable in SEND while rvalid=1 and rready=0.
REQ-018 SHALL, on an R handshake that is not the last beat, pre-read the next index in the same cycle so that rvalid stays 1 and beats run back-to-back when rready is held high.
REQ-019 SHALL, on the R handshake of the last beat (rlast=1), go to IDLE and drop rvalid on the next cycle.
REQ-020 SHALL advance the index as follows: INCR (01) index+1 per beat, FIXED (00) no change; the index does not wrap and stops being valid at index >= WINDOW_DEPTH.
REQ-021 SHALL drive rresp=OKAY (00) for a beat with index < WINDOW_DEPTH, arsize==DATA_BYTE_SHIFT and burst in {00,01}; otherwise it drives rresp=SLVERR (10) with rdata=0 and still completes the full beat count.
REQ-022 SHALL, when an INCR burst crosses into index >= WINDOW_DEPTH, return SLVERR for the crossing beat and all later beats only.
REQ-023 SHALL keep rlast=1 only on beat number arlen+1; a single-beat burst (arlen=0) has rlast=1 on its only beat.
REQ-024 SHALL give the write port priority-free access in any state: memory[wr_addr] <= wr_data when wr_en=1, and writes with wr_addr >= WINDOW_DEPTH are ignored.
REQ-025 SHALL be read-first on a same-cycle write and read of the same index: the read returns the old data.
REQ-026 SHALL, with rready=1 throughout, have a latency of AR handshake at cycle T, first beat valid at T+2, and last beat at T+2+arlen.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, enter IDLE and set rvalid=0, rlast=0, rresp=00, rid=0, rdata=0 and busy=0; arready is 1 from the first cycle after rst is released.
REQ-028 SHALL, on a reset in the middle of a burst, abandon the burst with no further beats; memory contents are not cleared by reset.

Verification
REQ-029 Fill words 0..99 with pattern = index replicated; apply araddr=0x40, arlen=3, INCR, arsize=5 with rready=1 -> data for indices 2,3,4,5 arrives on consecutive cycles starting at T+2, rresp=00 on every beat, rlast=1 on the 4th beat only.
REQ-030 Apply araddr=0xC60 (index 99), arlen=2, INCR -> beat 1 has OKAY with data 99, beats 2 and 3 have SLVERR with rdata=0, and rlast=1 on beat 3.
REQ-031 Apply araddr=0x20, arlen=1, and toggle rready 0/1 every cycle -> rdata stays stable while stalled, exactly 2 beats complete, and arready=0 until the cycle after rlast is accepted.
REQ-032 Apply arsize=3 or arburst=10 with arlen=0 -> one beat with rresp=10, rdata=0 and rlast=1.
REQ-033 Write 0xAA.. to index 7 in the same cycle that index 7 is fetched -> old data is returned; a re-read returns 0xAA...
REQ-034 Apply rst=1 during beat 2 of an arlen=7 burst -> rvalid=0 on the next cycle; after release arready=1, and a new burst returns correct, unchanged memory data.

Source files
------------

// File: rtl/axi_window_read_slave.sv
// AXI4 read-only slave exposing a small word-addressed RAM window.
// A side write port fills the RAM and may write in any state.
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   wr_en/addr/data   - RAM write port (out-of-window addresses ignored)
//   s_axi_ar*         - AXI4 read-address channel (arready only in IDLE)
//   s_axi_r*          - AXI4 read-data channel, all outputs registered
//   busy              - high whenever a burst is being served
module axi_window_read_slave #(
  parameter int unsigned DATA_BYTE_WIDTH    = 32,
  parameter int unsigned DATA_BYTE_SHIFT    = 5,
  parameter int unsigned WINDOW_DEPTH_INDEX = 7,
  parameter int unsigned WINDOW_DEPTH       = 100
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [WINDOW_DEPTH_INDEX-1:0]   wr_addr,
  input  logic [DATA_BYTE_WIDTH*8-1:0]    wr_data,
  input  logic [3:0]                      s_axi_arid,
  input  logic [31:0]                     s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  input  logic [2:0]                      s_axi_arsize,
  input  logic [1:0]                      s_axi_arburst,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [3:0]                      s_axi_rid,
  output logic [DATA_BYTE_WIDTH*8-1:0]    s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            busy
);

  localparam int unsigned DATA_W = DATA_BYTE_WIDTH * 8;
  // Index counter is wide enough that a 256-beat INCR never wraps back into the window.
  localparam int unsigned CNT_W  = WINDOW_DEPTH_INDEX + 9;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t                state;
  logic [DATA_W-1:0]     mem [WINDOW_DEPTH];
  logic [CNT_W-1:0]      idx;
  logic [7:0]            beats_left;
  logic                  incr;
  logic                  cfg_err;

  logic [CNT_W-1:0]      idx_next;
  logic [CNT_W-1:0]      rd_idx;
  logic                  rd_ok;
  logic [DATA_W-1:0]     rd_word;
  logic                  unused_addr_bits;

  // Only the word-index slice of araddr is decoded.
  assign unused_addr_bits = ^s_axi_araddr;

  // Write port; nonblocking update makes a same-edge read see the old word.
  always_ff @(posedge clk) begin
    if (wr_en && (CNT_W'(wr_addr) < CNT_W'(WINDOW_DEPTH))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read address selection: FETCH reads the latched index, SEND pre-reads the next one.
  always_comb begin
    idx_next = idx;
    rd_idx   = idx;
    rd_ok    = 1'b0;
    rd_word  = '0;
    if (incr) begin
      idx_next = idx + CNT_W'(1);
    end
    if (state == SEND) begin
      rd_idx = idx_next;
    end
    rd_ok = !cfg_err && (rd_idx < CNT_W'(WINDOW_DEPTH));
    if (rd_ok) begin
      rd_word = mem[rd_idx[WINDOW_DEPTH_INDEX-1:0]];
    end
  end

  // Burst control and registered AXI outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      busy          <= 1'b0;
      idx           <= '0;
      beats_left    <= '0;
      incr          <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            busy          <= 1'b1;
            state         <= FETCH;
            s_axi_rid     <= s_axi_arid;
            idx           <= CNT_W'(s_axi_araddr[DATA_BYTE_SHIFT +: WINDOW_DEPTH_INDEX]);
            beats_left    <= s_axi_arlen;
            incr          <= (s_axi_arburst == BURST_INCR);
            // Wrong beat size or WRAP/reserved burst makes every beat an error.
            cfg_err       <= (s_axi_arsize != 3'(DATA_BYTE_SHIFT)) || s_axi_arburst[1];
          end
        end
        FETCH: begin
          s_axi_rvalid <= 1'b1;
          s_axi_rdata  <= rd_word;
          s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          s_axi_rlast  <= (beats_left == 8'd0);
          state        <= SEND;
        end
        SEND: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              state         <= IDLE;
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              busy          <= 1'b0;
              s_axi_arready <= 1'b1;
            end else begin
              idx         <= idx_next;
              beats_left  <= beats_left - 8'd1;
              s_axi_rdata <= rd_word;
              s_axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
              s_axi_rlast <= (beats_left == 8'd1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_window_read_slave.sv
// Directed bench for axi_window_read_slave: a per-burst beat list built from a
// shadow memory, checked every cycle, plus literal pins on captured beats.
module tb_axi_window_read_slave;

  typedef struct {
    logic [255:0] data;
    logic [1:0]   resp;
    logic         last;
    logic [3:0]   id;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [6:0]   wr_addr;
  logic [255:0] wr_data;
  logic [3:0]   s_axi_arid;
  logic [31:0]  s_axi_araddr;
  logic [7:0]   s_axi_arlen;
  logic [2:0]   s_axi_arsize;
  logic [1:0]   s_axi_arburst;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [3:0]   s_axi_rid;
  logic [255:0] s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;
  logic         s_axi_rvalid;
  logic         s_axi_rready;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [255:0] ref_mem [0:127];
  beat_t        exp_q [$];
  beat_t        cap_q [$];
  bit           chk_en        = 1'b0;
  bit           in_flight     = 1'b0;
  bit           first_pending = 1'b0;
  int           exp_first_cyc = 0;
  int           exp_last_cyc  = -1;

  axi_window_read_slave dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the expected beat list.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("arready", 256'(s_axi_arready), 256'(!in_flight));
      chk("busy", 256'(busy), 256'(in_flight));
      if (s_axi_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rvalid", 256'(s_axi_rvalid), 256'(0));
        end else begin
          chk("rdata", s_axi_rdata, exp_q[0].data);
          chk("rresp", 256'(s_axi_rresp), 256'(exp_q[0].resp));
          chk("rlast", 256'(s_axi_rlast), 256'(exp_q[0].last));
          chk("rid", 256'(s_axi_rid), 256'(exp_q[0].id));
          if (first_pending) begin
            chk("first_beat_cycle", 256'(cyc), 256'(exp_first_cyc));
            first_pending = 1'b0;
          end
          if (s_axi_rready) begin
            cap_q.push_back('{s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid});
            if (exp_q[0].last) begin
              in_flight = 1'b0;
              if (exp_last_cyc >= 0) chk("last_beat_cycle", 256'(cyc), 256'(exp_last_cyc));
            end
            void'(exp_q.pop_front());
          end
        end
      end else if (exp_q.size() != 0 && !first_pending) begin
        chk("rvalid_gap", 256'(s_axi_rvalid), 256'(1));
      end
    end
  end

  function automatic logic [255:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {32{b}};
  endfunction

  task automatic wr_word(input int addr, input logic [255:0] data);
    wr_en   = 1'b1;
    wr_addr = 7'(addr);
    wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (addr < 100) ref_mem[addr] = data;
  endtask

  task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input bit fetch_wr);
    bit hs;
    int n;
    int base;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = size;
    s_axi_arburst = burst;
    s_axi_arid    = id;
    s_axi_arvalid = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = s_axi_arready;
      @(posedge clk); #1;
      n++;
    end
    s_axi_arvalid = 1'b0;
    if (!hs) begin
      chk("ar_handshake_timeout", 256'(hs), 256'(1));
    end else begin
      base = int'((addr >> 5) & 32'h7F);
      for (int b = 0; b <= int'(len); b++) begin
        int    i;
        bit    ok;
        beat_t e;
        i  = (burst == 2'b01) ? base + b : base;
        ok = (i < 100) && (size == 3'd5) && (burst == 2'b00 || burst == 2'b01);
        if (ok) e.data = ref_mem[i];
        else    e.data = '0;
        e.resp = ok ? 2'b00 : 2'b10;
        e.last = (b == int'(len));
        e.id   = id;
        exp_q.push_back(e);
      end
      in_flight     = 1'b1;
      first_pending = 1'b1;
      exp_first_cyc = cyc + 1;
      exp_last_cyc  = cyc + 1 + int'(len);
      if (fetch_wr) begin
        // Lands on the same edge as the FETCH read of the latched index.
        wr_en   = 1'b1;
        wr_addr = 7'd7;
        wr_data = {32{8'hAA}};
        ref_mem[7] = {32{8'hAA}};
      end
    end
  endtask

  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input bit toggle,
                           input bit fetch_wr);
    int n;
    cap_q.delete();
    s_axi_rready = toggle ? 1'b0 : 1'b1;
    issue_ar(addr, len, size, burst, id, fetch_wr);
    if (toggle) exp_last_cyc = -1;
    n = 0;
    while (in_flight && n < 2000) begin
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (toggle) s_axi_rready = ~s_axi_rready;
      n++;
    end
    wr_en = 1'b0;
    s_axi_rready = 1'b1;
    if (in_flight) begin
      chk("burst_timeout", 256'(in_flight), 256'(0));
      in_flight = 1'b0;
      first_pending = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rvalid"}, 256'(s_axi_rvalid), 256'(0));
    chk({tag, "_rlast"}, 256'(s_axi_rlast), 256'(0));
    chk({tag, "_rresp"}, 256'(s_axi_rresp), 256'(0));
    chk({tag, "_rid"}, 256'(s_axi_rid), 256'(0));
    chk({tag, "_rdata"}, s_axi_rdata, 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd5;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arready_after_reset", 256'(s_axi_arready), 256'(1));
    chk_en = 1'b1;

    for (int i = 0; i < 100; i++) wr_word(i, pat(i));
    wr_word(100, {32{8'h5A}});

    // Aligned 4-beat INCR from index 2
    run_burst(32'h40, 8'd3, 3'd5, 2'b01, 4'd3, 1'b0, 1'b0);
    chk("incr4_count", 256'(cap_q.size()), 256'(4));
    if (cap_q.size() == 4) begin
      chk("incr4_beat1_data", cap_q[0].data, {32{8'h02}});
      chk("incr4_beat4_data", cap_q[3].data, {32{8'h05}});
      chk("incr4_beat3_last", 256'(cap_q[2].last), 256'(0));
      chk("incr4_beat4_last", 256'(cap_q[3].last), 256'(1));
    end

    // High address bits ignored
    run_burst(32'hFFFF_F040, 8'd0, 3'd5, 2'b01, 4'hF, 1'b0, 1'b0);

    // INCR from the last word crosses out of the window
    run_burst(32'hC60, 8'd2, 3'd5, 2'b01, 4'd1, 1'b0, 1'b0);
    chk("cross_count", 256'(cap_q.size()), 256'(3));
    if (cap_q.size() == 3) begin
      chk("cross_beat1_data", cap_q[0].data, {32{8'h63}});
      chk("cross_beat1_resp", 256'(cap_q[0].resp), 256'(0));
      chk("cross_beat2_resp", 256'(cap_q[1].resp), 256'(2));
      chk("cross_beat2_data", cap_q[1].data, 256'(0));
      chk("cross_beat3_last", 256'(cap_q[2].last), 256'(1));
    end

    // rready toggling every cycle
    run_burst(32'h20, 8'd1, 3'd5, 2'b01, 4'd6, 1'b1, 1'b0);
    chk("stall_count", 256'(cap_q.size()), 256'(2));
    if (cap_q.size() == 2) chk("stall_beat2_data", cap_q[1].data, {32{8'h02}});

    // Bad size / WRAP burst
    run_burst(32'h40, 8'd0, 3'd3, 2'b01, 4'd2, 1'b0, 1'b0);
    chk("badsize_count", 256'(cap_q.size()), 256'(1));
    if (cap_q.size() == 1) begin
      chk("badsize_resp", 256'(cap_q[0].resp), 256'(2));
      chk("badsize_data", cap_q[0].data, 256'(0));
      chk("badsize_last", 256'(cap_q[0].last), 256'(1));
    end
    run_burst(32'h40, 8'd0, 3'd5, 2'b10, 4'd2, 1'b0, 1'b0);
    if (cap_q.size() == 1) chk("wrap_resp", 256'(cap_q[0].resp), 256'(2));

    // FIXED burst repeats index 10
    run_burst(32'h140, 8'd2, 3'd5, 2'b00, 4'd4, 1'b0, 1'b0);
    if (cap_q.size() == 3) chk("fixed_beat3_data", cap_q[2].data, {32{8'h0A}});

    // Start outside the window
    run_burst(32'hDC0, 8'd1, 3'd5, 2'b01, 4'd8, 1'b0, 1'b0);

    // Write during fetch returns the old word, re-read sees the new one
    run_burst(32'hE0, 8'd0, 3'd5, 2'b01, 4'd7, 1'b0, 1'b1);
    if (cap_q.size() == 1) chk("rdfirst_old", cap_q[0].data, {32{8'h07}});
    run_burst(32'hE0, 8'd0, 3'd5, 2'b01, 4'd7, 1'b0, 1'b0);
    if (cap_q.size() == 1) chk("rdfirst_new", cap_q[0].data, {32{8'hAA}});

    // Maximum-length INCR from index 0
    run_burst(32'h0, 8'd255, 3'd5, 2'b01, 4'd9, 1'b0, 1'b0);
    chk("long_count", 256'(cap_q.size()), 256'(256));
    if (cap_q.size() == 256) begin
      chk("long_beat100_resp", 256'(cap_q[99].resp), 256'(0));
      chk("long_beat101_resp", 256'(cap_q[100].resp), 256'(2));
      chk("long_beat256_last", 256'(cap_q[255].last), 256'(1));
    end

    // Reset during beat 2 of an 8-beat burst
    cap_q.delete();
    s_axi_rready = 1'b1;
    issue_ar(32'h40, 8'd7, 3'd5, 2'b01, 4'd5, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_beat2_valid", 256'(s_axi_rvalid), 256'(1));
    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("abort");
    exp_q.delete();
    in_flight = 1'b0;
    first_pending = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_arready", 256'(s_axi_arready), 256'(1));
    chk_en = 1'b1;
    run_burst(32'h40, 8'd3, 3'd5, 2'b01, 4'd3, 1'b0, 1'b0);
    if (cap_q.size() == 4) chk("post_reset_beat1", cap_q[0].data, {32{8'h02}});

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
